// File: rtl/divider_sequencer_if.sv
// Handshake/bus bundle between control logic, sequencer and divider.
// The sequencer takes the slave side; control/divider act as master.
interface divider_sequencer_if #(
    parameter int AW = 2,
    parameter int PW = 16,
    parameter int CW = 8
);
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [PW-1:0] wrPeriod;
    logic [CW-1:0] wrCount;
    logic [AW-1:0] seqLen;
    logic          loop;
    logic          start;
    logic          stop;
    logic          divPulse;
    logic          divEn;
    logic          divLd;
    logic [PW-1:0] divPin;
    logic          busy;
    logic [AW-1:0] curIdx;
    logic          entryDone;
    logic          done;

    modport master (
        output wrEn, wrAddr, wrPeriod, wrCount,
        output seqLen, loop, start, stop, divPulse,
        input  divEn, divLd, divPin, busy,
        input  curIdx, entryDone, done
    );

    modport slave (
        input  wrEn, wrAddr, wrPeriod, wrCount,
        input  seqLen, loop, start, stop, divPulse,
        output divEn, divLd, divPin, busy,
        output curIdx, entryDone, done
    );
endinterface

// File: rtl/divider_sequencer.sv
// Steps one divider through a programmed list of (period, pulse count)
// entries, loading each period and counting divider pulses per entry.
module divider_sequencer #(
    parameter int ENTRIES = 4,
    parameter int AW      = 2,
    parameter int PW      = 16,
    parameter int CW      = 8
) (
    input  logic                clk,
    input  logic                rst,
    divider_sequencer_if.slave  io_seq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_tabPer [ENTRIES];
    logic [CW-1:0] r_tabCnt [ENTRIES];

    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic [AW-1:0] r_seqLen;
    logic [AW-1:0] w_seqLen_nxt;
    logic [PW-1:0] r_curPeriod;
    logic [PW-1:0] w_curPeriod_nxt;
    logic [CW-1:0] r_remaining;
    logic [CW-1:0] w_remaining_nxt;
    logic          r_fromRun;
    logic          w_fromRun_nxt;
    logic          r_done;
    logic          w_done_nxt;

    logic [PW-1:0] w_tabPer;
    logic [CW-1:0] w_tabCnt;

    assign w_tabPer = r_tabPer[r_idx];
    assign w_tabCnt = r_tabCnt[r_idx];

    // Table is writable in any state; working copies only refresh in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tabPer[i] <= '0;
                r_tabCnt[i] <= '0;
            end
        end else if (io_seq.wrEn) begin
            r_tabPer[io_seq.wrAddr] <= io_seq.wrPeriod;
            r_tabCnt[io_seq.wrAddr] <= io_seq.wrCount;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_seqLen    <= '0;
            r_curPeriod <= '0;
            r_remaining <= '0;
            r_fromRun   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_seqLen    <= w_seqLen_nxt;
            r_curPeriod <= w_curPeriod_nxt;
            r_remaining <= w_remaining_nxt;
            r_fromRun   <= w_fromRun_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_seqLen_nxt    = r_seqLen;
        w_curPeriod_nxt = r_curPeriod;
        w_remaining_nxt = r_remaining;
        w_fromRun_nxt   = 1'b0;
        w_done_nxt      = 1'b0;

        unique case (1'b1)
            (r_state == S_IDLE): begin
                if (io_seq.start && !io_seq.stop) begin
                    w_seqLen_nxt = io_seq.seqLen;
                    w_idx_nxt    = '0;
                    w_state_nxt  = S_LOAD;
                end
            end
            (r_state == S_LOAD): begin
                if (io_seq.stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_curPeriod_nxt = w_tabPer;
                    w_remaining_nxt = w_tabCnt;
                    // A zero count skips the entry without entryDone.
                    if (w_tabCnt != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            (r_state == S_RUN): begin
                if (io_seq.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (io_seq.divPulse) begin
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == CW'(1)) begin
                        w_state_nxt   = S_NEXT;
                        w_fromRun_nxt = 1'b1;
                    end
                end
            end
            (r_state == S_NEXT): begin
                if (io_seq.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx != r_seqLen) begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = S_LOAD;
                end else if (io_seq.loop) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pin shows the table value in LOAD and the latched copy otherwise,
    // so the divider reloads a stable period on terminal count.
    assign io_seq.divEn     = (r_state == S_LOAD) || (r_state == S_RUN);
    assign io_seq.divLd     = (r_state == S_LOAD);
    assign io_seq.divPin    = (r_state == S_LOAD) ? w_tabPer : r_curPeriod;
    assign io_seq.busy      = (r_state != S_IDLE);
    assign io_seq.curIdx    = r_idx;
    assign io_seq.entryDone = (r_state == S_NEXT) && r_fromRun;
    assign io_seq.done      = r_done;

endmodule
